pwm_sar_adc: RTL
================

// Module: pwm_sar_adc
// PURPOSE
//  Successive-approximation ADC built from a PWM output, an external RC filter and an external comparator.
//  Produces the 8-bit pwm_adc_out code consumed by the frequency-word and amplitude controls of the DDS.
//  Converts continuously while enabled; each new result is flagged with a one-cycle odone pulse.
// PARAMETERS
//  DATA_W          8   result width; equals the SAR bit count and the PWM counter width
//  SETTLE_PERIODS  16  full PWM periods the RC filter settles per bit decision (legal range 1..255)
// PORTS
//  iclk         in   1       system clock
//  irstn        in   1       asynchronous active-low reset
//  ien          in   1       conversion enable; level-sensitive
//  icmp         in   1       comparator output, asynchronous; 1 = Vin >= filtered PWM voltage
//  opwm         out  1       PWM drive to the RC filter
//  pwm_adc_out  out  DATA_W  last completed conversion result
//  odone        out  1       one-cycle pulse when pwm_adc_out updates
// BEHAVIOUR
//  Reset values: opwm=0, pwm_adc_out=0, odone=0, FSM=IDLE, PWM counter=0, trial=0.
//  PWM counter pwm_cnt
//   - DATA_W bits, free-running 0..2^DATA_W-1, then wraps. It runs regardless of ien.
//   - opwm is registered: opwm <= (pwm_cnt < trial). trial=0 gives a constant 0; 255 gives 255/256 duty.
//  Trial register updates only on the cycle where pwm_cnt == all-ones (the period boundary).
//   Each new duty therefore starts cleanly at pwm_cnt=0.
//  icmp passes through a 2-FF synchronizer (cmp_s). Decisions use cmp_s only.
//  FSM states:
//   - IDLE: waits for ien=1 and a period boundary. On that boundary it loads trial = 1<<(DATA_W-1) and bit index = DATA_W-1, then moves to SETTLE.
//   - SETTLE: counts SETTLE_PERIODS period boundaries.
//     At the SETTLE_PERIODS-th boundary it samples cmp_s:
//     * cmp_s=0: clear the current trial bit.
//     * Bit index > 0: set the next lower bit in the same update, decrement the index, stay in SETTLE.
//     * Bit index = 0: go to DONE.
//   - DONE (one cycle):
//     * pwm_adc_out <= trial; odone=1.
//     * Trial holds its value; the next load happens in IDLE.
//     * If ien=1, the next conversion starts at the next boundary.
//  Latency: exactly DATA_W*SETTLE_PERIODS*2^DATA_W clocks from the first trial load to the final decision, plus 1 clock to odone.
//  Boundary conditions:
//   - ien falls mid-conversion: abort to IDLE on the next clock and set trial=0 at the next period boundary.
//     pwm_adc_out holds its value and odone is not pulsed.
//   - ien rises mid-period: nothing starts until the next boundary.
//   - All comparisons true gives 0xFF. All false gives 0x00.
//   - Asynchronous reset mid-conversion returns every register to its reset value immediately.
// CONFIGURATION
//  PWM_ADC_AVG_EN defined:
//   - Accumulates 4 consecutive raw conversions in a DATA_W+2-bit sum.
//   - pwm_adc_out <= sum>>2 (truncated) and odone pulses once per 4 conversions.
//   - Dropping ien clears the sum and the count.
//  PWM_ADC_AVG_EN undefined: every raw conversion updates pwm_adc_out as described above.
// STRUCTURE
//  Shared package / header dds_pkg holds:
//   - SAR FSM state localparams (IDLE=2'b00, SETTLE=2'b01, DONE=2'b10)
//   - ADC_DATA_W=8, which also sizes pwm_adc_out in the accumulator
//  One sub-module, pwm_gen: counter, registered compare and boundary strobe.
//  Synchronizer, FSM and averager stay inline.
// TESTING
//  Bench setup:
//   - SETTLE_PERIODS=2; each conversion = 8*2*256 = 4096 clocks.
//   - Comparator model: icmp = (vin_code >= trial), delayed by 1 clock.
//  Scenarios (stimulus -> required response):
//   1. Reset held with ien=1, then released -> opwm=0, pwm_adc_out=0, odone=0; first trial 0x80 appears at the first boundary.
//   2. vin_code=0xA5 -> trial sequence 80,C0,A0,B0,A8,A4,A6,A5; pwm_adc_out=0xA5 with odone 4097 clocks after the first load.
//   3. vin_code=0xFF, then 0x00 -> results 0xFF, then 0x00; opwm stays constantly 0 during the trial=0 period.
//   4. ien dropped at clock 2000 of a conversion with pwm_adc_out=0x3C -> no odone, output stays 0x3C; restart requires ien=1 plus a boundary.
//   5. icmp toggled asynchronously off the clock edge -> decisions match cmp_s two cycles later, with no X or metastable output.
//   6. With PWM_ADC_AVG_EN and vin_code = 0x10, 0x11, 0x12, 0x13 -> a single odone pulse, pwm_adc_out=0x11.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared DDS definitions: SAR FSM state encodings and the PWM ADC result width.
package dds_pkg;

    localparam int ADC_DATA_W = 8;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] SETTLE = 2'b01;
    localparam logic [1:0] DONE   = 2'b10;

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter with registered duty compare and period-boundary strobe.
module pwm_gen #(
    parameter int DATA_W = 8
) (
    input  logic              iclk,
    input  logic              irstn,
    input  logic [DATA_W-1:0] trial,
    output logic              opwm,
    output logic              boundary
);

    logic [DATA_W-1:0] pwm_cnt;

    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            pwm_cnt <= '0;
            opwm    <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            opwm    <= (pwm_cnt < trial);
        end
    end

    // High on the last count of a period, so anything loaded here takes effect at pwm_cnt=0.
    assign boundary = &pwm_cnt;

endmodule

// File: rtl/pwm_sar_adc.sv
// SAR ADC using PWM + external RC filter + comparator. Define PWM_ADC_AVG_EN to
// average four raw conversions per published result.
module pwm_sar_adc
    import dds_pkg::*;
#(
    parameter int DATA_W         = ADC_DATA_W,
    parameter int SETTLE_PERIODS = 16
) (
    input  logic              iclk,
    input  logic              irstn,
    input  logic              ien,
    input  logic              icmp,
    output logic              opwm,
    output logic [DATA_W-1:0] pwm_adc_out,
    output logic              odone
);

    localparam int                IDX_W       = $clog2(DATA_W);
    localparam logic [IDX_W-1:0]  IDX_MSB     = IDX_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] TRIAL_MSB   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_PERIODS - 1);

    logic [1:0]        state;
    logic [IDX_W-1:0]  bit_idx;
    logic [7:0]        settle_cnt;
    logic [DATA_W-1:0] trial;
    logic [DATA_W-1:0] trial_dec;
    logic              cmp_m;
    logic              cmp_s;
    logic              boundary;

`ifdef PWM_ADC_AVG_EN
    logic [DATA_W+1:0] avg_sum;
    logic [DATA_W+1:0] avg_sum_nxt;
    logic [1:0]        avg_cnt;

    function automatic logic [DATA_W-1:0] avg4_trunc(input logic [DATA_W+1:0] sum);
        return sum[DATA_W+1:2];
    endfunction

    assign avg_sum_nxt = avg_sum + (DATA_W+2)'(trial);
`endif

    pwm_gen #(.DATA_W(DATA_W)) u_pwm (
        .iclk     (iclk),
        .irstn    (irstn),
        .trial    (trial),
        .opwm     (opwm),
        .boundary (boundary)
    );

    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            cmp_m <= 1'b0;
            cmp_s <= 1'b0;
        end else begin
            cmp_m <= icmp;
            cmp_s <= cmp_m;
        end
    end

    // Keep the tested bit only if Vin >= trial, and try the next lower bit in the same update.
    always_comb begin
        trial_dec = trial;
        if (!cmp_s)
            trial_dec[bit_idx] = 1'b0;
        if (bit_idx != '0)
            trial_dec[bit_idx - 1'b1] = 1'b1;
    end

    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            state       <= IDLE;
            bit_idx     <= '0;
            settle_cnt  <= '0;
            trial       <= '0;
            pwm_adc_out <= '0;
            odone       <= 1'b0;
`ifdef PWM_ADC_AVG_EN
            avg_sum     <= '0;
            avg_cnt     <= '0;
`endif
        end else begin
            odone <= 1'b0;
`ifdef PWM_ADC_AVG_EN
            if (!ien) begin
                avg_sum <= '0;
                avg_cnt <= '0;
            end
`endif
            case (state)
                IDLE: begin
                    if (boundary) begin
                        if (ien) begin
                            trial      <= TRIAL_MSB;
                            bit_idx    <= IDX_MSB;
                            settle_cnt <= '0;
                            state      <= SETTLE;
                        end else begin
                            trial <= '0;
                        end
                    end
                end
                SETTLE: begin
                    if (!ien) begin
                        state <= IDLE;
                    end else if (boundary) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            trial      <= trial_dec;
                            settle_cnt <= '0;
                            if (bit_idx == '0)
                                state <= DONE;
                            else
                                bit_idx <= bit_idx - 1'b1;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (ien) begin
`ifdef PWM_ADC_AVG_EN
                        if (avg_cnt == 2'd3) begin
                            pwm_adc_out <= avg4_trunc(avg_sum_nxt);
                            odone       <= 1'b1;
                            avg_sum     <= '0;
                            avg_cnt     <= '0;
                        end else begin
                            avg_sum <= avg_sum_nxt;
                            avg_cnt <= avg_cnt + 1'b1;
                        end
`else
                        pwm_adc_out <= trial;
                        odone       <= 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
